sprite_linebuf: RTL and testbench

Double-buffered (ping-pong) pixel line buffer that sits directly upstream of the raster timing generator. It feeds the generator's 12-bit RGB input from the HPOS/VPOS counters the generator exports. A renderer fills the off-screen bank for the next line through a request/done handshake. The on-screen bank is read out at pixel rate and cleared behind the read beam, so each bank starts empty (transparent) when it is handed back to the renderer.

---
 rtl/sprite_linebuf.sv | 131 +++++++++++++
 tb/tb_sprite_linebuf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_linebuf.sv
// Ping-pong pixel line buffer feeding the raster timing generator.
// The renderer fills the off-screen bank while the on-screen bank is read out and cleared behind the beam.
module sprite_linebuf #(
  parameter int DW    = 12,
  parameter int DEPTH = 320,
  parameter int AW    = 9
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PCLK_EN,
  input  logic [8:0]    HPOS,
  input  logic [8:0]    VPOS,
  output logic          REQ,
  output logic [8:0]    REQ_LINE,
  input  logic          ACK,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [DW-1:0] WR_DATA,
  input  logic          DONE,
  output logic [DW-1:0] RD_RGB,
  output logic          LINE_VALID,
  output logic [7:0]    UNDERRUN_CNT,
  output logic [1:0]    STATE_DBG
);

  // Handshake: REQ stays high with REQ_LINE stable until ACK is seen; writes are
  // accepted from REQ until DONE; a line swap preempts any unfinished request.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          sel_q;
  logic [8:0]    vprev_q;
  logic [1:0]    warm_q;
  logic [8:0]    req_line_q;
  logic [DW-1:0] rd_rgb_q;
  logic          line_valid_q;
  logic [7:0]    unr_q;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  logic          swap, warm_done, active, hpos_ok, wr_ok, clr;
  logic [AW-1:0] rd_addr, a0, a1;
  logic [DW-1:0] d0, d1, rd_data;
  logic          we0, we1;

  assign swap      = PCLK_EN && (VPOS != vprev_q);
  assign warm_done = (warm_q == 2'd2);
  assign active    = (state_q == S_REQ) || (state_q == S_BUSY);
  assign hpos_ok   = ({1'b0, HPOS} < 10'(DEPTH));
  assign wr_ok     = WR_EN && active && ({1'b0, WR_ADDR} < (AW+1)'(DEPTH));
  assign clr       = PCLK_EN && hpos_ok;
  assign rd_addr   = hpos_ok ? AW'(HPOS) : '0;
  assign rd_data   = sel_q ? mem1[rd_addr] : mem0[rd_addr];

  // The display bank's write port does clear-behind; the other bank's takes renderer writes.
  always_comb begin
    we0 = 1'b0;
    a0  = '0;
    d0  = '0;
    we1 = 1'b0;
    a1  = '0;
    d1  = '0;
    if (!sel_q) begin
      we0 = clr;
      a0  = rd_addr;
      we1 = wr_ok;
      a1  = WR_ADDR;
      d1  = WR_DATA;
    end else begin
      we1 = clr;
      a1  = rd_addr;
      we0 = wr_ok;
      a0  = WR_ADDR;
      d0  = WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (we0) mem0[a0] <= d0;
    if (we1) mem1[a1] <= d1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (DONE)     state_d = S_DONE;
        else if (ACK) state_d = S_BUSY;
      end
      S_BUSY:  if (DONE) state_d = S_DONE;
      default: state_d = state_q;
    endcase
    if (swap && warm_done) state_d = S_REQ;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      vprev_q      <= '0;
      warm_q       <= '0;
      req_line_q   <= '0;
      rd_rgb_q     <= '0;
      line_valid_q <= 1'b0;
      unr_q        <= '0;
    end else begin
      state_q <= state_d;
      if (PCLK_EN) begin
        vprev_q  <= VPOS;
        rd_rgb_q <= (hpos_ok && line_valid_q) ? rd_data : '0;
      end
      if (swap) begin
        sel_q        <= ~sel_q;
        // A DONE arriving on the swap cycle still completes the outgoing line.
        line_valid_q <= (state_q == S_DONE) || (active && DONE);
        if (!warm_done) warm_q <= warm_q + 2'd1;
        if (warm_done)  req_line_q <= VPOS + 9'd1;
        if (active && !DONE && (unr_q != 8'hFF)) unr_q <= unr_q + 8'd1;
      end
    end
  end

  assign REQ          = (state_q == S_REQ);
  assign REQ_LINE     = req_line_q;
  assign RD_RGB       = rd_rgb_q;
  assign LINE_VALID   = line_valid_q;
  assign UNDERRUN_CNT = unr_q;
  assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Bench for sprite_linebuf: drives full raster lines plus a renderer between lines,
// scoring each RD_RGB sample against the image the renderer is expected to have produced.
module tb_sprite_linebuf;
  localparam int DW    = 12;
  localparam int DEPTH = 320;
  localparam int AW    = 9;
  localparam int H_END = 330;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          PCLK_EN;
  logic [8:0]    HPOS;
  logic [8:0]    VPOS;
  logic          REQ;
  logic [8:0]    REQ_LINE;
  logic          ACK;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          DONE;
  logic [DW-1:0] RD_RGB;
  logic          LINE_VALID;
  logic [7:0]    UNDERRUN_CNT;
  logic [1:0]    STATE_DBG;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] nxt  [DEPTH];
  logic [DW-1:0] disp [DEPTH];
  int            exp_unr;

  sprite_linebuf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .HPOS(HPOS), .VPOS(VPOS),
    .REQ(REQ), .REQ_LINE(REQ_LINE), .ACK(ACK), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .DONE(DONE), .RD_RGB(RD_RGB), .LINE_VALID(LINE_VALID),
    .UNDERRUN_CNT(UNDERRUN_CNT), .STATE_DBG(STATE_DBG)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one pixel-rate cycle, with optional renderer strobes on the same cycle
  task automatic pix(input logic [8:0] h, input logic [8:0] v, input logic dn, input logic ak,
                     input logic we, input logic [8:0] wa, input logic [11:0] wd);
    logic [DW-1:0] e;
    @(negedge CLK);
    HPOS = h; VPOS = v; PCLK_EN = 1'b1; DONE = dn; ACK = ak;
    WR_EN = we; WR_ADDR = wa; WR_DATA = wd;
    if (int'(h) < DEPTH) exp_q.push_back(disp[h]);
    else                 exp_q.push_back('0);
    @(posedge CLK); #1;
    PCLK_EN = 1'b0; DONE = 1'b0; ACK = 1'b0; WR_EN = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("rgb h=%0d v=%0d", h, v), RD_RGB, e);
  endtask

  // renderer-only cycle (no pixel enable)
  task automatic rcyc(input logic ak, input logic we, input logic [8:0] wa,
                      input logic [11:0] wd, input logic dn);
    @(negedge CLK);
    ACK = ak; WR_EN = we; WR_ADDR = wa; WR_DATA = wd; DONE = dn;
    @(posedge CLK); #1;
    ACK = 1'b0; WR_EN = 1'b0; DONE = 1'b0;
  endtask

  task automatic ack_req();
    rcyc(1'b1, 1'b0, '0, '0, 1'b0);
    check("req_drop_after_ack", REQ, 1'b0);
  endtask

  task automatic wr(input logic [8:0] a, input logic [11:0] d, input bit accepted);
    rcyc(1'b0, 1'b1, a, d, 1'b0);
    if (accepted) nxt[a] = d;
  endtask

  task automatic done_p();
    rcyc(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  // the bank handed to the display is the finished image or blank; the new write bank starts empty
  task automatic swap_model(input bit complete);
    for (int i = 0; i < DEPTH; i++) begin
      disp[i] = complete ? nxt[i] : '0;
      nxt[i]  = '0;
    end
  endtask

  task automatic run_line(input logic [8:0] v, input logic dn, input logic ak, input logic we,
                          input logic [8:0] wa, input logic [11:0] wd);
    for (int h = 0; h < H_END; h++) begin
      if (h == 0) pix(9'd0, v, dn, ak, we, wa, wd);
      else        pix(9'(h), v, 1'b0, 1'b0, 1'b0, '0, '0);
      if (h == 5) begin
        @(negedge CLK); HPOS = 9'd6;
        @(posedge CLK); #1;
        check("rgb_hold", RD_RGB, disp[5]);
      end
    end
    pix(9'd496, v, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic plain_line(input logic [8:0] v);
    run_line(v, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_status(input logic lv, input logic rq, input logic [8:0] rl);
    check("line_valid", LINE_VALID, lv);
    check("req", REQ, rq);
    if (rq) check("req_line", REQ_LINE, rl);
    check("underrun", UNDERRUN_CNT, exp_unr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_req"}, REQ, 1'b0);
    check({tag, "_req_line"}, REQ_LINE, 9'd0);
    check({tag, "_rgb"}, RD_RGB, 12'd0);
    check({tag, "_line_valid"}, LINE_VALID, 1'b0);
    check({tag, "_underrun"}, UNDERRUN_CNT, 8'd0);
    check({tag, "_state"}, STATE_DBG, 2'd0);
  endtask

  initial begin
    RESET = 1'b1; PCLK_EN = 1'b0; HPOS = '0; VPOS = '0; ACK = 1'b0;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; DONE = 1'b0;
    exp_unr = 0;
    for (int i = 0; i < DEPTH; i++) begin nxt[i] = '0; disp[i] = '0; end
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    @(negedge CLK); RESET = 1'b0;

    // warm-up: no requests for the first two swaps
    plain_line(9'd0); chk_status(1'b0, 1'b0, '0);
    plain_line(9'd1); chk_status(1'b0, 1'b0, '0);
    plain_line(9'd2); chk_status(1'b0, 1'b0, '0);
    plain_line(9'd3); chk_status(1'b0, 1'b1, 9'd4);

    // first completed line
    ack_req(); wr(9'd5, 12'hF00, 1'b1); done_p();
    swap_model(1'b1); plain_line(9'd4); chk_status(1'b1, 1'b1, 9'd5);

    // random image, out-of-range write and post-DONE write dropped
    ack_req();
    for (int i = 0; i < 8; i++)
      wr(9'($urandom_range(1, DEPTH - 1)), 12'($urandom_range(1, 4095)), 1'b1);
    wr(9'd320, 12'hFFF, 1'b0);
    done_p();
    wr(9'd9, 12'hABC, 1'b0);
    swap_model(1'b1); plain_line(9'd5); chk_status(1'b1, 1'b1, 9'd6);

    // reuse of the F00 bank: address 5 must have been cleared
    ack_req(); wr(9'd10, 12'h0AB, 1'b1); done_p();
    swap_model(1'b1); plain_line(9'd6); chk_status(1'b1, 1'b1, 9'd7);

    // acked but unfinished line: underrun, blank output despite bank data
    ack_req(); wr(9'd11, 12'h777, 1'b1);
    exp_unr = 1;
    swap_model(1'b0); plain_line(9'd7); chk_status(1'b0, 1'b1, 9'd8);

    // DONE and a write to address 7 on the swap cycle itself
    ack_req(); wr(9'd20, 12'h555, 1'b1);
    nxt[7] = 12'h0F0;
    swap_model(1'b1); run_line(9'd8, 1'b1, 1'b0, 1'b1, 9'd7, 12'h0F0);
    chk_status(1'b1, 1'b1, 9'd9);

    // unacked request underruns; ACK on the swap cycle is discarded
    exp_unr = 2;
    swap_model(1'b0); run_line(9'd9, 1'b0, 1'b1, 1'b0, '0, '0);
    chk_status(1'b0, 1'b1, 9'd10);
    ack_req(); done_p();
    swap_model(1'b1); plain_line(9'd10); chk_status(1'b1, 1'b1, 9'd11);

    // VPOS jumps and wraps
    exp_unr = 3;
    swap_model(1'b0); plain_line(9'd259); chk_status(1'b0, 1'b1, 9'd260);
    ack_req(); done_p();
    swap_model(1'b1); plain_line(9'd0); chk_status(1'b1, 1'b1, 9'd1);
    ack_req(); done_p();
    swap_model(1'b1); plain_line(9'd511); chk_status(1'b1, 1'b1, 9'd0);

    // saturation of the underrun counter with short lines
    for (int i = 0; i < 300; i++) begin
      pix(9'd400, 9'(i + 1), 1'b0, 1'b0, 1'b0, '0, '0);
      if (exp_unr < 255) exp_unr++;
      check("underrun_count", UNDERRUN_CNT, exp_unr);
      ack_req();
    end
    check("underrun_saturated", UNDERRUN_CNT, 8'd255);
    swap_model(1'b0);

    // valid line, then reset asserted mid-line between clock edges
    wr(9'd50, 12'hABC, 1'b1); done_p();
    swap_model(1'b1);
    for (int h = 0; h <= 50; h++) pix(9'(h), 9'd301, 1'b0, 1'b0, 1'b0, '0, '0);
    chk_status(1'b1, 1'b1, 9'd302);
    check("rgb_before_reset", RD_RGB, 12'hABC);
    @(negedge CLK); #2;
    RESET = 1'b1;
    #1;
    chk_reset_outputs("midline_reset");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
